// File: rtl/trace_stream_tx_pkg.sv
// Shared definitions for the trace stream transmitter.
// Holds the record geometry, the serializer state encoding, the word order
// inside a record, and a helper that assembles a record from its four words.
package trace_stream_tx_pkg;

  localparam int unsigned TRACE_REC_W = 128;
  localparam int unsigned TRACE_BYTES = 16;

  // Serializer state encoding
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  // Word slots within a record; slot 0 is sent first (most significant)
  localparam int unsigned WORD_SEQ   = 0;
  localparam int unsigned WORD_PC    = 1;
  localparam int unsigned WORD_INSTR = 2;
  localparam int unsigned WORD_ALU   = 3;

  typedef logic [TRACE_REC_W-1:0] trace_rec_t;

  function automatic trace_rec_t pack_rec(input logic [31:0] seq,
                                          input logic [31:0] pc,
                                          input logic [31:0] instr,
                                          input logic [31:0] alu);
    trace_rec_t rec;
    rec = '0;
    rec[TRACE_REC_W-1-32*WORD_SEQ   -: 32] = seq;
    rec[TRACE_REC_W-1-32*WORD_PC    -: 32] = pc;
    rec[TRACE_REC_W-1-32*WORD_INSTR -: 32] = instr;
    rec[TRACE_REC_W-1-32*WORD_ALU   -: 32] = alu;
    return rec;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Single-clock record FIFO for the trace transmitter.
// Ports:
//   clk, reset   clock and asynchronous active-low reset (clears pointers)
//   push, wdata  write a record; ignored when full
//   pop          advance the read pointer; ignored when empty
//   rdata        record at the head (valid when not empty)
//   full, empty  status on current state
//   level        records held, 0..DEPTH
module trace_fifo
  import trace_stream_tx_pkg::*;
#(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  trace_rec_t        wdata,
  input  logic              pop,
  output trace_rec_t        rdata,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   level
);

  trace_rec_t        mem [DEPTH];
  logic [ADDR_W:0]   wr_ptr_q;
  logic [ADDR_W:0]   rd_ptr_q;
  logic              do_push;
  logic              do_pop;

  // Extra MSB on each pointer tells full (MSBs differ) from empty (equal).
  assign full    = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                   (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign level   = wr_ptr_q - rd_ptr_q;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr_q[ADDR_W-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage needs no reset; pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q[ADDR_W-1:0]] <= wdata;
  end

endmodule

// File: rtl/trace_stream_tx.sv
// Trace transmitter for the single-cycle MIPS core.
// Captures {seq, pc, instruction, aluresout} when capture_en is high, queues
// records in a FIFO and streams each as 16 big-endian bytes over valid/ready.
// Ports:
//   clk, reset        clock and asynchronous active-low reset
//   capture_en        sample pc/instruction/aluresout this cycle
//   clear_overflow    synchronous clear of overflow and drop_count
//   out_data/valid/ready/last  byte stream; last marks byte 15 of a record
//   fifo_level        records queued (excluding the one being sent)
//   overflow          sticky drop flag
//   drop_count        saturating dropped-record count
module trace_stream_tx
  import trace_stream_tx_pkg::*;
#(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              capture_en,
  input  logic [31:0]       pc,
  input  logic [31:0]       instruction,
  input  logic [31:0]       aluresout,
  input  logic              clear_overflow,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic [ADDR_W:0]   fifo_level,
  output logic              overflow,
  output logic [15:0]       drop_count
);

  localparam logic [3:0] LAST_IDX = 4'(TRACE_BYTES - 1);

  logic [31:0] seq_q;
  logic [0:0]  state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  trace_rec_t  shreg_q, shreg_d;
  logic        overflow_q;
  logic [15:0] drop_count_q;

  logic        fifo_full, fifo_empty, fifo_pop;
  logic        push, drop;
  trace_rec_t  fifo_rdata;

  // Full is judged on pre-edge state, so a same-cycle pop cannot save a record.
  assign push = capture_en && !fifo_full;
  assign drop = capture_en && fifo_full;

  trace_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (pack_rec(seq_q, pc, instruction, aluresout)),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    shreg_d  = shreg_q;
    fifo_pop = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shreg_d  = fifo_rdata;
          idx_d    = '0;
          state_d  = ST_SEND;
        end
      end
      ST_SEND: begin
        if (out_ready) begin
          if (idx_q == LAST_IDX) begin
            // Reload straight from the FIFO to avoid a bubble between records
            if (!fifo_empty) begin
              fifo_pop = 1'b1;
              shreg_d  = fifo_rdata;
              idx_d    = '0;
            end else begin
              state_d  = ST_IDLE;
            end
          end else begin
            idx_d   = idx_q + 1'b1;
            shreg_d = {shreg_q[TRACE_REC_W-9:0], 8'h00};
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      shreg_q <= '0;
      seq_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      // Every capture attempt consumes a sequence number, dropped or not
      if (capture_en) seq_q <= seq_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end else if (clear_overflow) begin
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end else if (drop) begin
      overflow_q <= 1'b1;
      if (drop_count_q != 16'hFFFF) drop_count_q <= drop_count_q + 16'd1;
    end
  end

  assign out_valid  = (state_q == ST_SEND);
  assign out_data   = out_valid ? shreg_q[TRACE_REC_W-1 -: 8] : 8'h00;
  assign out_last   = out_valid && (idx_q == LAST_IDX);
  assign overflow   = overflow_q;
  assign drop_count = drop_count_q;

endmodule

// File: tb/tb_trace_stream_tx.sv
// Directed testbench for trace_stream_tx.
module tb_trace_stream_tx;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        capture_en = 1'b0;
  logic [31:0] pc = '0;
  logic [31:0] instruction = '0;
  logic [31:0] aluresout = '0;
  logic        clear_overflow = 1'b0;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_last;
  logic [3:0]  fifo_level;
  logic        overflow;
  logic [15:0] drop_count;

  int n_vec = 0;
  int n_err = 0;
  int got, gaps;
  logic [7:0] rx_data [0:255];
  logic [127:0] asm_rec;

  trace_stream_tx #(
    .DEPTH  (8),
    .ADDR_W (3)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .capture_en     (capture_en),
    .pc             (pc),
    .instruction    (instruction),
    .aluresout      (aluresout),
    .clear_overflow (clear_overflow),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_last       (out_last),
    .fifo_level     (fifo_level),
    .overflow       (overflow),
    .drop_count     (drop_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] got_v,
                          input logic [127:0] exp_v);
    n_vec++;
    if (got_v !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got_v, exp_v);
    end
  endtask

  // Stimulus record s: capture index s of a burst started right after reset
  function automatic logic [31:0] stim_pc(input int s);
    return 32'h00400000 + 32'(4 * s);
  endfunction
  function automatic logic [31:0] stim_ins(input int s);
    return 32'h20080005 + 32'(s);
  endfunction
  function automatic logic [31:0] stim_alu(input int s);
    return 32'h00000005 + 32'(s);
  endfunction
  function automatic logic [127:0] model(input int s);
    return {32'(s), stim_pc(s), stim_ins(s), stim_alu(s)};
  endfunction
  function automatic logic [7:0] model_byte(input int s, input int b);
    logic [127:0] r;
    r = model(s);
    return r[127 - 8 * b -: 8];
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    capture_en = 1'b0;
    clear_overflow = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // n captures on consecutive edges; returns at the negedge after the last one
  task automatic cap_burst(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      capture_en  = 1'b1;
      pc          = stim_pc(i);
      instruction = stim_ins(i);
      aluresout   = stim_alu(i);
    end
    @(negedge clk);
    capture_en = 1'b0;
  endtask

  // Accept n bytes; bp selects ready pattern 1,0,0 repeating. Checks every byte
  // against the model and that stalled outputs hold. Counts idle cycles after
  // the first accepted byte.
  task automatic drain(input int n, input bit bp, input int budget,
                       output int n_got, output int n_gaps);
    int   cyc;
    bit   stall;
    logic [7:0] hold_d;
    logic hold_l;
    cyc = 0; stall = 1'b0; n_got = 0; n_gaps = 0; hold_d = '0; hold_l = 1'b0;
    while (n_got < n && cyc < budget) begin
      @(negedge clk);
      if (stall) begin
        check_eq("hold_valid", 128'(out_valid), 128'(1));
        check_eq("hold_data", 128'(out_data), 128'(hold_d));
        check_eq("hold_last", 128'(out_last), 128'(hold_l));
      end
      out_ready = bp ? (cyc % 3 == 0) : 1'b1;
      stall = 1'b0;
      if (out_valid) begin
        if (out_ready) begin
          rx_data[n_got] = out_data;
          check_eq($sformatf("byte%0d", n_got), 128'(out_data),
                   128'(model_byte(n_got / 16, n_got % 16)));
          check_eq($sformatf("last%0d", n_got), 128'(out_last),
                   128'(n_got % 16 == 15));
          n_got++;
        end else begin
          stall  = 1'b1;
          hold_d = out_data;
          hold_l = out_last;
        end
      end else if (n_got > 0) begin
        n_gaps++;
      end
      cyc++;
    end
    check_eq("drain_count", 128'(n_got), 128'(n));
  endtask

  initial begin
    // Reset state
    #1;
    check_eq("rst_valid", 128'(out_valid), 128'(0));
    check_eq("rst_data", 128'(out_data), 128'(0));
    check_eq("rst_last", 128'(out_last), 128'(0));
    check_eq("rst_level", 128'(fifo_level), 128'(0));
    check_eq("rst_ovf", 128'(overflow), 128'(0));
    check_eq("rst_drops", 128'(drop_count), 128'(0));

    // 1: single record
    do_reset();
    out_ready = 1'b1;
    cap_burst(1);
    check_eq("t1_lat_valid", 128'(out_valid), 128'(0));
    check_eq("t1_lat_level", 128'(fifo_level), 128'(1));
    drain(16, 1'b0, 40, got, gaps);
    asm_rec = '0;
    for (int i = 0; i < 16; i++) asm_rec = {asm_rec[119:0], rx_data[i]};
    check_eq("t1_record", asm_rec, 128'h00000000_00400000_20080005_00000005);
    @(negedge clk);
    check_eq("t1_idle_after", 128'(out_valid), 128'(0));

    // 2: backpressure
    do_reset();
    cap_burst(1);
    drain(16, 1'b1, 100, got, gaps);
    @(negedge clk);
    check_eq("t2_idle_after", 128'(out_valid), 128'(0));

    // 3: back-to-back records, no bubbles
    do_reset();
    fork
      cap_burst(3);
      drain(48, 1'b0, 100, got, gaps);
    join
    check_eq("t3_gaps", 128'(gaps), 128'(0));
    @(negedge clk);
    check_eq("t3_idle_after", 128'(out_valid), 128'(0));

    // 4: overflow with the receiver stalled
    do_reset();
    out_ready = 1'b0;
    cap_burst(11);
    check_eq("t4_level", 128'(fifo_level), 128'(8));
    check_eq("t4_ovf", 128'(overflow), 128'(1));
    check_eq("t4_drops", 128'(drop_count), 128'(2));
    check_eq("t4_head", 128'(out_data), 128'(8'h00));

    // 5: clear leaves FIFO contents alone
    clear_overflow = 1'b1;
    @(negedge clk);
    clear_overflow = 1'b0;
    check_eq("t5_ovf", 128'(overflow), 128'(0));
    check_eq("t5_drops", 128'(drop_count), 128'(0));
    check_eq("t5_level", 128'(fifo_level), 128'(8));
    drain(144, 1'b0, 200, got, gaps);
    check_eq("t4_gaps", 128'(gaps), 128'(0));
    @(negedge clk);
    check_eq("t4_idle_after", 128'(out_valid), 128'(0));
    check_eq("t4_level_after", 128'(fifo_level), 128'(0));

    // 6: asynchronous reset mid-record
    do_reset();
    out_ready = 1'b0;
    cap_burst(3);
    drain(7, 1'b0, 20, got, gaps);
    @(negedge clk);
    out_ready = 1'b0;
    check_eq("t6_byte7", 128'(out_data), 128'(model_byte(0, 7)));
    check_eq("t6_level_pre", 128'(fifo_level), 128'(2));
    #2;
    reset = 1'b0;
    #1;
    check_eq("t6_valid", 128'(out_valid), 128'(0));
    check_eq("t6_level", 128'(fifo_level), 128'(0));
    check_eq("t6_data", 128'(out_data), 128'(0));
    @(negedge clk);
    reset = 1'b1;
    cap_burst(1);
    drain(16, 1'b0, 40, got, gaps);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/trace_stream_tx.md
Name: trace_stream_tx

Overview:
- Synthesizable trace transmitter for the single-cycle MIPS processor.
- Captures one per-cycle record {sequence, PC, instruction, ALU result} whenever `capture_en` is high, and buffers records in a small FIFO.
- Serializes each record as a 16-byte stream over a valid/ready byte interface.
- This is the producing end of the per-cycle trace that the bench consumes. An off-chip or host reader receives it.

Parameters:
- DEPTH, 8, FIFO depth in records; power of two, at least 2.
- ADDR_W, 3, log2(DEPTH).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- capture_en  in  1  sample the trace inputs this cycle.
- pc  in  32  current PC.
- instruction  in  32  current instruction word.
- aluresout  in  32  current ALU result.
- clear_overflow  in  1  synchronous clear of `overflow` and `drop_count`.
- out_data  out  8  stream byte.
- out_valid  out  1  `out_data` valid.
- out_ready  in  1  receiver accepts the byte.
- out_last  out  1  marks byte 15 of a record.
- fifo_level  out  ADDR_W+1  records held in the FIFO (excludes the record being sent).
- overflow  out  1  sticky; set when a record is dropped.
- drop_count  out  16  dropped-record count, saturates at 16'hFFFF.

Behaviour:
- Reset (reset=0, asynchronous) clears:
  - all outputs to 0;
  - the FIFO pointers;
  - the sequence counter;
  - the FSM, to IDLE.
- Reset mid-record abandons the record; no partial resume.

Capture:
- At each rising edge with `capture_en`=1, form the 128-bit record {seq[31:0], pc, instruction, aluresout}.
- `seq` increments (wrapping at 2^32) on every capture attempt, including dropped ones, so gaps are visible downstream.
- FIFO full is evaluated on pre-edge state.
  - If full, the record is dropped, `overflow` is set, and `drop_count` increments (saturating).
  - A same-cycle pop does not save it.
- If not full, the record is written and `fifo_level` increments the same edge, unless a pop also occurs. A simultaneous push and pop leaves the level unchanged.
- `clear_overflow` in the same cycle as a drop: the clear wins for `overflow`, and `drop_count` becomes 0.

Serializer FSM:
- IDLE:
  - `out_valid`=0.
  - If the FIFO is non-empty at an edge, pop the head into the 128-bit shift register, set byte index to 0, and go to SEND.
  - First byte latency: a record captured at edge N appears with `out_valid`=1 after edge N+1 when the FIFO was empty and the FSM idle.
- SEND:
  - `out_valid`=1.
  - `out_data` = byte[index], big-endian within each word, words in order seq, pc, instruction, aluresout. Index 0 = seq[31:24]; index 15 = aluresout[7:0].
  - `out_last` = (index==15).
  - While `out_ready`=0, `out_data`, `out_last` and the index are held stable.
  - On handshake (`out_valid`&&`out_ready`) with index<15, the index increments.
  - On handshake at index 15:
    - if the FIFO is non-empty, pop the next record, set index to 0 and stay in SEND (no bubble cycle);
    - otherwise go to IDLE.
- Throughput: one byte per cycle with `out_ready` held high; sustained capture faster than one per 16 cycles eventually overflows.
- `fifo_level` ranges 0..DEPTH; pointers wrap modulo DEPTH, with one extra bit to distinguish full from empty.

Decomposition:
- Shared package holds:
  - TRACE_REC_W=128 and TRACE_BYTES=16;
  - the state encoding (IDLE=0, SEND=1);
  - the word-order constants.
- One sub-module, trace_fifo: synchronous single-clock FIFO (DEPTH, width 128) with push, pop, full, empty and level. The serializer FSM lives in the top.

Test Plan:
1. Single record.
   - Stimulus: after reset release, one capture with pc=32'h00400000, instruction=32'h20080005, aluresout=32'h00000005; `out_ready`=1.
   - Required: 16 bytes 00 00 00 00 00 40 00 00 20 08 00 05 00 00 00 05, `out_last` on the 16th byte only, then `out_valid`=0.
2. Backpressure.
   - Stimulus: same record with `out_ready` toggling 1,0,0,1,...
   - Required: the byte sequence is unchanged, and `out_data` is stable during every low-ready cycle.
3. Back-to-back.
   - Stimulus: 3 consecutive captures with `out_ready`=1.
   - Required: 48 contiguous valid bytes, seq fields 0,1,2, no idle cycle between records.
4. Overflow.
   - Stimulus: `out_ready`=0, 11 consecutive captures, DEPTH=8.
   - Required:
     - 1 record in the shift register and 8 in the FIFO;
     - `fifo_level`=8, `overflow`=1, `drop_count`=2;
     - after draining, the seq fields read 0..8.
5. Clear.
   - Stimulus: assert `clear_overflow` for one cycle after scenario 4.
   - Required: `overflow`=0 and `drop_count`=0; FIFO contents are unaffected.
6. Reset mid-record.
   - Stimulus: drop `reset` low at byte index 7.
   - Required: `out_valid`=0 immediately (asynchronous), `fifo_level`=0, and the next capture after release carries seq=0.
